// File: rtl/wbit_fifo_pkg.sv
// Shared types for the byte FIFO: per-cycle operation encoding and its decoder.
package wbit_fifo_pkg;

  // Accepted operation for one cycle, bit 0 = push, bit 1 = pop.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Combine the already-qualified push/pop strobes into one operation code.
  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    logic [1:0] code;
    code = {pop, push};
    return fifo_op_e'(code);
  endfunction

endpackage

// File: rtl/wbit_fifo.sv
// Single-clock FIFO with a registered read port. A pop loads the head entry into
// read_data, which then holds until the next accepted pop. Push when full and pop
// when empty are silently ignored. Flags come from the registered occupancy count.
module wbit_fifo
  import wbit_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic                  push_s;
  logic                  pop_s;
  fifo_op_e              op_s;

  // Flags reflect the current registered count, so a same-cycle pop never frees
  // room for a push and a same-cycle push never feeds a pop.
  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty  = (count_q == {CNT_W{1'b0}});
  assign push_s = write_en && !full;
  assign pop_s  = read_en && !empty;
  assign op_s   = decode_op(push_s, pop_s);

  assign read_data = read_data_q;

  // Next-state for pointers, occupancy and the read-data holding register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    read_data_d = read_data_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1'b1);
      read_data_d = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d    = rd_ptr_q;
      read_data_d = read_data_q;
    end
    case (op_s)
      OP_PUSH: count_d = count_q + CNT_W'(1'b1);
      OP_POP:  count_d = count_q - CNT_W'(1'b1);
      OP_BOTH: count_d = count_q;
      OP_IDLE: count_d = count_q;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards contents by clearing pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= {PTR_W{1'b0}};
      rd_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      read_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
    end
  end

  // Storage write port; left unreset so it maps onto a plain dual-port RAM.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

endmodule

// File: tb/tb_wbit_fifo.sv
// Directed self-checking bench for wbit_fifo at depth 4, byte width.
module tb_wbit_fifo;

  logic       clk;
  logic       rst;
  logic       write_en;
  logic       read_en;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       full;
  logic       empty;

  int chk_cnt;
  int pass_cnt;

  wbit_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_en   (write_en),
    .read_en    (read_en),
    .write_data (write_data),
    .read_data  (read_data),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given strobes; returns 1 time unit after the edge.
  task automatic cyc(input logic we, input logic re, input logic [7:0] wd);
    write_en   = we;
    read_en    = re;
    write_data = wd;
    @(posedge clk);
    #1;
    write_en   = 1'b0;
    read_en    = 1'b0;
    write_data = 8'h00;
  endtask

  logic [7:0] exp_q [$];
  logic [7:0] v;

  initial begin
    chk_cnt    = 0;
    pass_cnt   = 0;
    rst        = 1'b1;
    write_en   = 1'b0;
    read_en    = 1'b0;
    write_data = 8'h00;

    // 1: reset
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_rdata", read_data, 8'h00);
    rst = 1'b0;

    // 2: three pushes, three pops with hold between pops
    cyc(1'b1, 1'b0, 8'hA1);
    check("t2_empty_after_push", empty, 1'b0);
    cyc(1'b1, 1'b0, 8'hB2);
    cyc(1'b1, 1'b0, 8'hC3);
    cyc(1'b0, 1'b1, 8'h00);
    check("t2_pop1", read_data, 8'hA1);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check("t2_hold1", read_data, 8'hA1);
    cyc(1'b0, 1'b1, 8'h00);
    check("t2_pop2", read_data, 8'hB2);
    cyc(1'b0, 1'b0, 8'h00);
    check("t2_hold2", read_data, 8'hB2);
    cyc(1'b0, 1'b1, 8'h00);
    check("t2_pop3", read_data, 8'hC3);
    check("t2_empty", empty, 1'b1);

    // 3: overflow, fifth byte dropped
    for (int i = 1; i <= 4; i++) begin
      check("t3_full_before", full, 1'b0);
      cyc(1'b1, 1'b0, 8'(i));
    end
    check("t3_full", full, 1'b1);
    cyc(1'b1, 1'b0, 8'h05);
    check("t3_full_after_drop", full, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check("t3_pop", read_data, 32'(i));
      check("t3_full_clear", full, 1'b0);
    end
    check("t3_empty", empty, 1'b1);

    // 4: underflow keeps last data
    cyc(1'b1, 1'b0, 8'h5A);
    cyc(1'b0, 1'b1, 8'h00);
    check("t4_pop", read_data, 8'h5A);
    cyc(1'b0, 1'b1, 8'h00);
    check("t4_underflow_rdata", read_data, 8'h5A);
    check("t4_underflow_empty", empty, 1'b1);

    // 5: steady push+pop with wrap, then push-on-full with pop
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    exp_q = '{8'h11, 8'h22};
    for (int i = 0; i < 6; i++) begin
      v = 8'h33 + 8'(i * 17);
      exp_q.push_back(v);
      cyc(1'b1, 1'b1, v);
      check("t5_both_rdata", read_data, exp_q.pop_front());
      check("t5_both_empty", empty, 1'b0);
      check("t5_both_full", full, 1'b0);
    end
    cyc(1'b1, 1'b0, 8'h99);
    cyc(1'b1, 1'b0, 8'hAA);
    check("t5_full", full, 1'b1);
    cyc(1'b1, 1'b1, 8'hBB);
    check("t5_fullpop_rdata", read_data, 8'h77);
    check("t5_fullpop_count3", full, 1'b0);
    cyc(1'b0, 1'b1, 8'h00);
    check("t5_drain1", read_data, 8'h88);
    cyc(1'b0, 1'b1, 8'h00);
    check("t5_drain2", read_data, 8'h99);
    cyc(1'b0, 1'b1, 8'h00);
    check("t5_drain3", read_data, 8'hAA);
    check("t5_drained_empty", empty, 1'b1);

    // 5b: pop on empty with same-cycle push is rejected
    cyc(1'b1, 1'b1, 8'hC5);
    check("t5b_rdata_held", read_data, 8'hAA);
    check("t5b_not_empty", empty, 1'b0);
    cyc(1'b0, 1'b1, 8'h00);
    check("t5b_pop", read_data, 8'hC5);

    // 6: reset mid-operation
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    cyc(1'b1, 1'b0, 8'h03);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    check("t6_rst_empty", empty, 1'b1);
    check("t6_rst_full", full, 1'b0);
    check("t6_rst_rdata", read_data, 8'h00);
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b0, 1'b1, 8'h00);
    check("t6_pop", read_data, 8'h77);
    check("t6_empty", empty, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
